counter_load_arbiter: RTL and testbench

//  Shares one sync_load_up_counter (4-bit loadable up counter) between NUM_REQ requesters.

---
 rtl/counter_load_arbiter_if.sv | 27 ++
 rtl/counter_load_arbiter.sv | 112 +++++++++++
 tb/tb_counter_load_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_load_arbiter_if.sv
// Requester/counter-side bus of counter_load_arbiter.
// The master side is requester logic plus the shared counter; the slave side is the arbiter.
interface counter_load_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned IDW     = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_value;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [IDW-1:0]           owner_id;
  logic                     ctr_load;
  logic [WIDTH-1:0]         ctr_d_in;
  logic [WIDTH-1:0]         ctr_count;

  modport master (
    output req, req_value, ctr_count,
    input  gnt, done, busy, owner_id, ctr_load, ctr_d_in
  );

  modport slave (
    input  req, req_value, ctr_count,
    output gnt, done, busy, owner_id, ctr_load, ctr_d_in
  );
endinterface

// File: rtl/counter_load_arbiter.sv
// Round-robin arbiter sharing one loadable up counter between NUM_REQ requesters.
// Grants one owner, loads its start value, and pulses done when the counter reaches all-ones.
module counter_load_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  counter_load_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 load_q, load_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0]     din_q, din_d;

  logic                 pick_valid;
  logic [IDW-1:0]       pick_idx;
  logic [IDW-1:0]       scan_idx;
  logic [WIDTH-1:0]     pick_value;

  // First requester with req set, scanning from the round-robin pointer.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((32'(ptr_q) + k) % NUM_REQ);
      if (!pick_valid && bus.req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    pick_value = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDW'(i)) pick_value = bus.req_value[i*WIDTH +: WIDTH];
    end
  end

  // Next-state and next-output logic; gnt/done/load are single-cycle pulses by default.
  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    done_d  = '0;
    load_d  = 1'b0;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    din_d   = din_q;
    busy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = LOAD;
          for (int unsigned i = 0; i < NUM_REQ; i++) gnt_d[i] = (pick_idx == IDW'(i));
          owner_d = pick_idx;
          din_d   = pick_value;
          load_d  = 1'b1;
          ptr_d   = IDW'((32'(pick_idx) + 32'd1) % NUM_REQ);
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (bus.ctr_count == '1) begin
          state_d = IDLE;
          for (int unsigned i = 0; i < NUM_REQ; i++) done_d[i] = (owner_q == IDW'(i));
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      din_q   <= din_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.owner_id = owner_q;
  assign bus.ctr_load = load_q;
  assign bus.ctr_d_in = din_q;

endmodule

// File: tb/tb_counter_load_arbiter.sv
// Bench for counter_load_arbiter: directed scenarios plus random traffic against a
// transaction-level model that predicts each grant and its done edge from the start value.
module tb_counter_load_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 4;
  localparam int unsigned IDW     = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] cnt = '0;
  int               n_cmp = 0;
  int               n_bad = 0;
  bit               cmp_on = 1'b0;
  bit               auto_drop = 1'b1;

  // Model outputs
  logic [NUM_REQ-1:0] x_gnt = '0;
  logic [NUM_REQ-1:0] x_done = '0;
  logic               x_busy = 1'b0;
  logic               x_load = 1'b0;
  logic [IDW-1:0]     m_owner = '0;
  logic [IDW-1:0]     m_ptr = '0;
  logic [WIDTH-1:0]   m_dval = '0;
  bit                 m_active = 1'b0;
  int unsigned        m_done_edge = 0;
  int unsigned        e_cnt = 0;

  counter_load_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  counter_load_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared loadable up counter, free-running, never reset here.
  always @(posedge clk) cnt <= bus.ctr_load ? bus.ctr_d_in : cnt + WIDTH'(1);
  assign bus.ctr_count = cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a grant of value V at edge e completes at edge e + 2^WIDTH - V + 1.
  initial begin : model
    int unsigned rq, idx, start;
    bit found;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_active = 1'b0; m_ptr = '0; m_owner = '0; m_dval = '0;
        x_gnt = '0; x_done = '0; x_busy = 1'b0; x_load = 1'b0;
      end else begin
        e_cnt++;
        x_gnt = '0; x_done = '0; x_load = 1'b0;
        if (m_active) begin
          if (e_cnt == m_done_edge) begin
            x_done   = NUM_REQ'(32'd1 << m_owner);
            m_active = 1'b0;
          end
        end else begin
          rq = 32'(bus.req); start = 32'(m_ptr); found = 1'b0;
          for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (start + k) % NUM_REQ;
            if (!found && ((rq >> idx) & 32'd1) != 0) begin
              found       = 1'b1;
              m_owner     = IDW'(idx);
              m_dval      = WIDTH'(32'(bus.req_value) >> (idx * WIDTH));
              m_ptr       = IDW'((idx + 1) % NUM_REQ);
              m_active    = 1'b1;
              m_done_edge = e_cnt + (32'd1 << WIDTH) - 32'(m_dval) + 1;
              x_gnt       = NUM_REQ'(32'd1 << idx);
              x_load      = 1'b1;
            end
          end
        end
        x_busy = m_active;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("gnt",      32'(bus.gnt),      32'(x_gnt));
      chk("done",     32'(bus.done),     32'(x_done));
      chk("busy",     32'(bus.busy),     32'(x_busy));
      chk("ctr_load", 32'(bus.ctr_load), 32'(x_load));
      chk("owner_id", 32'(bus.owner_id), 32'(m_owner));
      chk("ctr_d_in", 32'(bus.ctr_d_in), 32'(m_dval));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (auto_drop) bus.req = bus.req & ~bus.gnt;
    end
  endtask

  task automatic wait_gnt(input int budget, output logic [NUM_REQ-1:0] g);
    int n = 0;
    do begin tick(1); n++; end while (bus.gnt == '0 && n < budget);
    g = bus.gnt;
  endtask

  task automatic wait_done(input int budget, output int n, output logic [NUM_REQ-1:0] d);
    n = 0;
    do begin tick(1); n++; end while (bus.done == '0 && n < budget);
    d = bus.done;
  endtask

  // Asynchronous reset mid-cycle, held across two edges, released mid-cycle.
  task automatic do_reset();
    #3 rst = 1'b0;
    #1;
    chk("rst_busy",  32'(bus.busy),     32'd0);
    chk("rst_gnt",   32'(bus.gnt),      32'd0);
    chk("rst_done",  32'(bus.done),     32'd0);
    chk("rst_load",  32'(bus.ctr_load), 32'd0);
    chk("rst_owner", 32'(bus.owner_id), 32'd0);
    chk("rst_d_in",  32'(bus.ctr_d_in), 32'd0);
    tick(2);
    #3 rst = 1'b1;
    tick(1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [NUM_REQ-1:0] g, d;
    int n;
    bus.req = '0;
    bus.req_value = '0;
    #1 rst = 1'b0;
    #2 cmp_on = 1'b1;
    tick(2);
    chk("init_busy", 32'(bus.busy),     32'd0);
    chk("init_gnt",  32'(bus.gnt),      32'd0);
    chk("init_d_in", 32'(bus.ctr_d_in), 32'd0);
    #3 rst = 1'b1;
    tick(1);

    // Single request on requester 1 with start value C
    bus.req_value = 16'h00C0;
    bus.req = 4'b0010;
    wait_gnt(20, g);
    chk("t2_gnt",   32'(g),            32'h2);
    chk("t2_load",  32'(bus.ctr_load), 32'd1);
    chk("t2_d_in",  32'(bus.ctr_d_in), 32'hC);
    chk("t2_owner", 32'(bus.owner_id), 32'd1);
    tick(1);
    chk("t2_cnt_c", 32'(cnt),          32'hC);
    chk("t2_gnt0",  32'(bus.gnt),      32'd0);
    tick(3);
    chk("t2_cnt_f", 32'(cnt),          32'hF);
    chk("t2_nodone", 32'(bus.done),    32'd0);
    tick(1);
    chk("t2_done",  32'(bus.done),     32'h2);
    chk("t2_idle",  32'(bus.busy),     32'd0);
    tick(1);
    chk("t2_done0", 32'(bus.done),     32'd0);

    // Mid-sim reset; restores ptr to 0
    do_reset();

    // Simultaneous requests 0 and 2, then 0 and 3 after ptr moves to 3
    bus.req_value = 16'h0B0A;
    bus.req = 4'b0101;
    wait_gnt(20, g);     chk("t3_gnt0", 32'(g), 32'h1);
    wait_done(40, n, d); chk("t3_done0", 32'(d), 32'h1);
    wait_gnt(20, g);     chk("t3_gnt2", 32'(g), 32'h4);
    bus.req = bus.req | 4'b1001;
    wait_done(40, n, d); chk("t3_done2", 32'(d), 32'h4);
    wait_gnt(20, g);     chk("t3_gnt3", 32'(g), 32'h8);
    wait_done(40, n, d);
    wait_gnt(20, g);     chk("t3_gnt0b", 32'(g), 32'h1);
    wait_done(40, n, d);

    // Fairness: all requesters held with value E
    do_reset();
    auto_drop = 1'b0;
    bus.req_value = 16'hEEEE;
    bus.req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(20, g);
      chk("t4_gnt", 32'(g), 32'd1 << (k % 4));
      if (k == 4) bus.req = '0;
      wait_done(20, n, d);
      chk("t4_lat",  32'(n), 32'd3);
      chk("t4_done", 32'(d), 32'd1 << (k % 4));
    end
    auto_drop = 1'b1;

    // Boundary start values F and 0 (ptr is 1 here)
    bus.req_value = 16'h0F00;
    bus.req = 4'b0100;
    wait_gnt(20, g);     chk("t5_gnt_f", 32'(g), 32'h4);
    wait_done(40, n, d); chk("t5_lat_f", 32'(n), 32'd2);
    bus.req_value = 16'h0000;
    bus.req = 4'b1000;
    wait_gnt(20, g);     chk("t5_gnt_0", 32'(g), 32'h8);
    wait_done(40, n, d); chk("t5_lat_0", 32'(n), 32'd17);

    // Reset while running at count 7; pending requests then arbitrate from ptr 0
    bus.req_value = 16'h0005;
    bus.req = 4'b0001;
    wait_gnt(20, g);     chk("t6_gnt", 32'(g), 32'h1);
    tick(3);
    chk("t6_cnt7", 32'(cnt),      32'h7);
    chk("t6_busy", 32'(bus.busy), 32'd1);
    bus.req_value = 16'h9898;
    bus.req = 4'b1010;
    do_reset();
    chk("t6_regnt", 32'(bus.gnt),      32'h2);
    chk("t6_d_in",  32'(bus.ctr_d_in), 32'h9);
    wait_done(40, n, d); chk("t6_done", 32'(d), 32'h2);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      bus.req_value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) bus.req = bus.req | NUM_REQ'($urandom);
      if ($urandom_range(0, 399) == 0) do_reset();
      else tick(1);
    end
    bus.req = '0;
    tick(40);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
